button_debounce_array: RTL

- Parametrised, multi-channel successor to the single-button debounce FSM.
- Each of N_CH raw, level-sensitive button inputs is synchronised and filtered with a programmable stable-sample count.
- Per channel it produces a debounced level plus one-cycle press, release and auto-repeat pulses.
- Sits between the board button pins and the game/control logic, on the 25 MHz system clock.

---
 rtl/button_debounce_array.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/button_debounce_array.sv
// button_debounce_array
//   Multi-channel button debouncer. Each raw button is synchronised,
//   then a four-state filter accepts a press or a release only after
//   STABLE_CYCLES consecutive identical synchronised samples. Each
//   channel also produces one-cycle press, release and auto-repeat pulses.
//
// Ports
//   clk            system clock (25 MHz)
//   rst            asynchronous reset, active-high
//   button[N_CH]   raw asynchronous buttons, 1 = pressed
//   level[N_CH]    debounced level
//   press[N_CH]    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   repeat_pulse   one-cycle auto-repeat pulse while held
//   ("release" and "repeat" are SystemVerilog keywords, hence the suffix.)

module button_debounce_array #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam logic [7:0]  CNT_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [23:0] DELAY     = 24'(REPEAT_DELAY);
  localparam logic [23:0] PERIOD    = 24'(REPEAT_PERIOD);
  localparam bit          REPEAT_EN = (REPEAT_DELAY > 0);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("button_debounce_array: STABLE_CYCLES must be in 2..255");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debounce_array: SYNC_STAGES must be at least 2");
  end
  if (REPEAT_PERIOD == 0) begin : g_bad_period
    $error("button_debounce_array: REPEAT_PERIOD must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [23:0]            rcnt, rcnt_nxt, rinc;
    logic                   rdone, rdone_nxt;  // first repeat already issued
    logic                   press_nxt, rel_nxt, rpt_nxt, level_nxt;
    logic                   level_q, press_q, rel_q, rpt_q;

    assign s = sync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], button[i]};
    end

    // Saturating increment: a very long hold can never wrap the counter
    // back onto a repeat threshold.
    assign rinc = (rcnt == 24'hFF_FFFF) ? rcnt : rcnt + 24'd1;

    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rcnt_nxt  = rcnt;
      rdone_nxt = rdone;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      rpt_nxt   = 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = 8'd1;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = 8'd0;
            press_nxt = 1'b1;
            rcnt_nxt  = 24'd0;
            rdone_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        HELD: begin
          if (!s) begin
            state_nxt = REL_CHK;
            cnt_nxt   = 8'd1;
          end else begin
            // Count held cycles; after the first repeat the counter
            // restarts and is compared against the period instead.
            rcnt_nxt = rinc;
            if (REPEAT_EN && rinc == (rdone ? PERIOD : DELAY)) begin
              rpt_nxt   = 1'b1;
              rcnt_nxt  = 24'd0;
              rdone_nxt = 1'b1;
            end
          end
        end
        REL_CHK: begin
          // rcnt is frozen here so a bounce back to HELD resumes timing.
          if (s) begin
            state_nxt = HELD;
            cnt_nxt   = 8'd0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            rel_nxt   = 1'b1;
            rcnt_nxt  = 24'd0;
            rdone_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign level_nxt = (state_nxt == HELD) || (state_nxt == REL_CHK);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= 8'd0;
        rcnt    <= 24'd0;
        rdone   <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        rcnt    <= rcnt_nxt;
        rdone   <= rdone_nxt;
        level_q <= level_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
        rpt_q   <= rpt_nxt;
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = rel_q;
    assign repeat_pulse[i]  = rpt_q;
  end

endmodule
